// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect request and
// the decoder-facing instruction stream. The fetch unit uses the master view
// and its environment (memory, branch unit, decoder) uses the slave view.
interface ifu_fetch_if;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_ren,
        output imem_raddr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    modport slave (
        input  imem_ren,
        input  imem_raddr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Issues sequential reads to a one-cycle-latency
// instruction memory and buffers returned words in a 2-entry FIFO for the
// decoder. A read is only issued when the FIFO is guaranteed to have room
// for its response, so the buffer can never overflow. A redirect restarts
// fetch at a new word-aligned address, discarding the in-flight response and
// everything buffered except a word popped in that same cycle.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic        clock,
    input logic        reset,
    ifu_fetch_if.master bus
);

    logic [31:0] pc;
    logic        pend;
    logic [31:0] pend_pc;
    logic [1:0]  cnt;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];

    logic        pop;
    logic        push;
    logic        ren;
    logic [2:0]  occ_after_pop;

    // Handshake decode and read-issue decision. Occupancy counts buffered
    // words plus the one in flight; a new read is allowed only if that total,
    // less this cycle's pop, leaves room for one more response.
    always_comb begin
        pop           = (cnt != 2'd0) & bus.inst_ready;
        push          = pend & ~bus.redirect_valid;
        occ_after_pop = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
        ren           = reset & ~bus.redirect_valid & (occ_after_pop <= 3'd1);
    end

    assign bus.imem_ren   = ren;
    assign bus.imem_raddr = pc;
    assign bus.inst_valid = (cnt != 2'd0);
    assign bus.inst       = fifo_inst[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];

    // Fetch pointer, in-flight tracking and FIFO occupancy/pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= 32'h0;
            cnt     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc      <= {bus.redirect_pc[31:2], 2'b00};
            pend    <= 1'b0;
            cnt     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            pend <= ren;
            if (ren) begin
                pend_pc <= pc;
                pc      <= pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage: capture the returning word with the address it was read from.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_pc[0]   <= 32'h0;
            fifo_pc[1]   <= 32'h0;
            fifo_inst[0] <= 32'h0;
            fifo_inst[1] <= 32'h0;
        end else if (push) begin
            fifo_pc[wr_ptr]   <= pend_pc;
            fifo_inst[wr_ptr] <= bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: reset values, a cycle-exact vector table covering
// stall/backpressure, redirect with flush, address wrap and back-to-back
// redirects, an asynchronous reset pulse followed by a throughput run, and
// a randomized run checked against a queue-based reference model.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic clock;
    logic reset;
    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: data for the address read in the previous cycle, junk otherwise.
    always @(posedge clock) begin
        if (bus.imem_ren)
            bus.imem_rdata <= bus.imem_raddr ^ KEY;
        else
            bus.imem_rdata <= $urandom;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] raddr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic ren, input logic [31:0] raddr,
                                input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ren = ren; v.raddr = raddr; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ent_t;

    vec_t tbl [24];

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        ent_t        q[$];
        logic [31:0] exp_fetch;
        logic        prev_stall;
        logic [31:0] prev_inst, prev_ipc;
        logic        rdy, rv, pop, exp_iv, exp_ren;
        logic [31:0] rpc;

        tbl[0]  = mk(0, 0, 32'h0,          1, RST_PC + 32'h00,  0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,          1, RST_PC + 32'h04,  0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,          0, RST_PC + 32'h08,  1, RST_PC);
        tbl[3]  = mk(0, 0, 32'h0,          0, RST_PC + 32'h08,  1, RST_PC);
        tbl[4]  = mk(0, 0, 32'h0,          0, RST_PC + 32'h08,  1, RST_PC);
        tbl[5]  = mk(1, 0, 32'h0,          1, RST_PC + 32'h08,  1, RST_PC);
        tbl[6]  = mk(1, 0, 32'h0,          1, RST_PC + 32'h0C,  1, RST_PC + 32'h04);
        tbl[7]  = mk(1, 0, 32'h0,          1, RST_PC + 32'h10,  1, RST_PC + 32'h08);
        tbl[8]  = mk(0, 1, 32'h8000_0102,  0, RST_PC + 32'h14,  1, RST_PC + 32'h0C);
        tbl[9]  = mk(0, 0, 32'h0,          1, 32'h8000_0100,    0, 32'h0);
        tbl[10] = mk(0, 0, 32'h0,          1, 32'h8000_0104,    0, 32'h0);
        tbl[11] = mk(1, 0, 32'h0,          1, 32'h8000_0108,    1, 32'h8000_0100);
        tbl[12] = mk(1, 0, 32'h0,          1, 32'h8000_010C,    1, 32'h8000_0104);
        tbl[13] = mk(1, 1, 32'hFFFF_FFF8,  0, 32'h8000_0110,    1, 32'h8000_0108);
        tbl[14] = mk(1, 0, 32'h0,          1, 32'hFFFF_FFF8,    0, 32'h0);
        tbl[15] = mk(1, 0, 32'h0,          1, 32'hFFFF_FFFC,    0, 32'h0);
        tbl[16] = mk(1, 0, 32'h0,          1, 32'h0000_0000,    1, 32'hFFFF_FFF8);
        tbl[17] = mk(1, 0, 32'h0,          1, 32'h0000_0004,    1, 32'hFFFF_FFFC);
        tbl[18] = mk(1, 0, 32'h0,          1, 32'h0000_0008,    1, 32'h0000_0000);
        tbl[19] = mk(1, 1, 32'h0000_1000,  0, 32'h0000_000C,    1, 32'h0000_0004);
        tbl[20] = mk(1, 1, 32'h0000_2003,  0, 32'h0000_1000,    0, 32'h0);
        tbl[21] = mk(1, 0, 32'h0,          1, 32'h0000_2000,    0, 32'h0);
        tbl[22] = mk(1, 0, 32'h0,          1, 32'h0000_2004,    0, 32'h0);
        tbl[23] = mk(1, 0, 32'h0,          1, 32'h0000_2008,    1, 32'h0000_2000);

        // Reset values while held in reset.
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check("rst.ren",   {31'h0, bus.imem_ren},   32'h0);
        check("rst.iv",    {31'h0, bus.inst_valid}, 32'h0);
        check("rst.raddr", bus.imem_raddr,          RST_PC);
        check("rst.inst",  bus.inst,                32'h0);
        check("rst.ipc",   bus.inst_pc,             32'h0);

        // Cycle-exact vector table starting at the first cycle after release.
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            #4;
            check($sformatf("tbl%0d.ren", i),   {31'h0, bus.imem_ren},   {31'h0, tbl[i].ren});
            if (tbl[i].ren)
                check($sformatf("tbl%0d.raddr", i), bus.imem_raddr, tbl[i].raddr);
            check($sformatf("tbl%0d.iv", i),    {31'h0, bus.inst_valid}, {31'h0, tbl[i].iv});
            if (tbl[i].iv) begin
                check($sformatf("tbl%0d.ipc", i),  bus.inst_pc, tbl[i].ipc);
                check($sformatf("tbl%0d.inst", i), bus.inst,    tbl[i].ipc ^ KEY);
            end
            @(posedge clock);
            #1;
        end

        // Asynchronous reset pulse mid-stream: outputs must clear with no clock edge.
        drive(1'b1, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("areset.ren",   {31'h0, bus.imem_ren},   32'h0);
        check("areset.iv",    {31'h0, bus.inst_valid}, 32'h0);
        check("areset.raddr", bus.imem_raddr,          RST_PC);
        check("areset.inst",  bus.inst,                32'h0);
        check("areset.ipc",   bus.inst_pc,             32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Full-rate streaming from RESET_PC with the decoder always ready.
        for (int k = 0; k < 10; k++) begin
            #4;
            check($sformatf("tput%0d.ren", k),   {31'h0, bus.imem_ren}, 32'h1);
            check($sformatf("tput%0d.raddr", k), bus.imem_raddr, RST_PC + 32'(4 * k));
            check($sformatf("tput%0d.iv", k),    {31'h0, bus.inst_valid}, (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check($sformatf("tput%0d.ipc", k),  bus.inst_pc, RST_PC + 32'(4 * (k - 2)));
                check($sformatf("tput%0d.inst", k), bus.inst,    (RST_PC + 32'(4 * (k - 2))) ^ KEY);
            end
            @(posedge clock);
            #1;
        end

        // Randomized run against a queue of issued reads.
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        exp_fetch  = RST_PC;
        prev_stall = 1'b0;
        prev_inst  = 32'h0;
        prev_ipc   = 32'h0;
        for (int c = 0; c < 1000; c++) begin
            rdy = ($urandom_range(0, 99) < 60);
            rv  = ($urandom_range(0, 99) < 3);
            rpc = $urandom;
            drive(rdy, rv, rpc);
            #4;
            exp_iv  = (q.size() > 0) && (q[0].cyc + 2 <= c);
            pop     = bus.inst_valid & rdy;
            exp_ren = !rv && ((q.size() - int'(pop)) <= 1);
            check("rnd.iv",  {31'h0, bus.inst_valid}, {31'h0, exp_iv});
            check("rnd.ren", {31'h0, bus.imem_ren},   {31'h0, exp_ren});
            if (bus.imem_ren)
                check("rnd.raddr", bus.imem_raddr, exp_fetch);
            if (bus.inst_valid && q.size() > 0) begin
                check("rnd.ipc",  bus.inst_pc, q[0].pc);
                check("rnd.inst", bus.inst,    q[0].pc ^ KEY);
            end
            if (prev_stall) begin
                check("rnd.hold_iv",   {31'h0, bus.inst_valid}, 32'h1);
                check("rnd.hold_inst", bus.inst,    prev_inst);
                check("rnd.hold_ipc",  bus.inst_pc, prev_ipc);
            end
            prev_stall = bus.inst_valid & !rdy & !rv;
            prev_inst  = bus.inst;
            prev_ipc   = bus.inst_pc;
            if (pop && q.size() > 0)
                void'(q.pop_front());
            if (rv) begin
                q.delete();
                exp_fetch = {rpc[31:2], 2'b00};
            end else if (bus.imem_ren) begin
                q.push_back('{pc: exp_fetch, cyc: c});
                exp_fetch = exp_fetch + 32'd4;
            end
            check("rnd.occ_le2", {31'h0, (q.size() <= 2)}, 32'h1);
            @(posedge clock);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
